muller_c_proj: RTL and testbench

- Clocked emulation of Muller C-elements for the async user project.
- Six primary inputs form three 2-input C-elements (pairs) and one 6-input C-element (all inputs).
- Also reports a "disagreement/holding" status flag and an 8-bit counter of rising transitions on the 6-input element output.
- Sits directly behind the project io_in pins; all state is synchronous to clk.

---
 rtl/muller_c_pkg.sv | 26 ++
 rtl/muller_c_proj_c_element.sv | 35 +++
 rtl/muller_c_proj.sv | 59 +++++
 tb/tb_muller_c_proj.sv | 124 ++++++++++++
 4 files changed

// File: rtl/muller_c_pkg.sv
// Shared constants and C-element update helper for the muller_c_proj user project.
package muller_c_pkg;

  localparam int unsigned NUM_PAIRS     = 3;
  localparam int unsigned IN_W          = 6;
  localparam logic        DEF_RESET_VAL = 1'b0;

  typedef enum logic [1:0] {
    C_HOLD  = 2'd0,
    C_CLEAR = 2'd1,
    C_SET   = 2'd2
  } c_action_e;

  // Unanimous inputs drive the output; any disagreement keeps the stored value.
  function automatic c_action_e c_action(input logic all_one, input logic all_zero);
    c_action_e act;
    act = C_HOLD;
    if (all_one) begin
      act = C_SET;
    end else if (all_zero) begin
      act = C_CLEAR;
    end
    return act;
  endfunction

endpackage

// File: rtl/muller_c_proj_c_element.sv
// Clocked N-input Muller C-element: output follows unanimous inputs, otherwise holds.
module c_element
  import muller_c_pkg::*;
#(
  parameter int unsigned N         = 2,
  parameter logic        RESET_VAL = DEF_RESET_VAL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic         out
);

  c_action_e act;
  logic      next_out;

  always_comb begin
    act      = c_action(&in, ~|in);
    next_out = out;
    case (act)
      C_SET:   next_out = 1'b1;
      C_CLEAR: next_out = 1'b0;
      default: next_out = out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= RESET_VAL;
    end else begin
      out <= next_out;
    end
  end

endmodule

// File: rtl/muller_c_proj.sv
// Three pairwise and one six-input clocked C-elements, with disagreement flag and rise counter.
module muller_c_proj
  import muller_c_pkg::*;
#(
  parameter logic        RESET_VAL = DEF_RESET_VAL,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      io_in,
  output logic [NUM_PAIRS-1:0] c_pair,
  output logic                 c_all,
  output logic                 holding,
  output logic [CNT_W-1:0]     rise_cnt
);

  logic rise;

  for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
    c_element #(
      .N        (2),
      .RESET_VAL(RESET_VAL)
    ) u_pair (
      .clk(clk),
      .rst(rst),
      .in (io_in[2*k+1 -: 2]),
      .out(c_pair[k])
    );
  end

  c_element #(
    .N        (IN_W),
    .RESET_VAL(RESET_VAL)
  ) u_all (
    .clk(clk),
    .rst(rst),
    .in (io_in),
    .out(c_all)
  );

  always_comb begin
    holding = ~(&io_in) & (|io_in);
    // c_all can only become 1 from 0 when every input is 1 this edge.
    rise    = ~c_all & (&io_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_cnt <= '0;
    end else if (rise) begin
      rise_cnt <= rise_cnt + 1'b1;
    end
  end

  a_hold_stable: assert property (@(posedge clk) (holding && !rst) |=> (c_all == $past(c_all)));

  c_rise_fall: cover property (@(posedge clk) disable iff (rst) $fell(c_all));

endmodule

// File: tb/tb_muller_c_proj.sv
// Directed-vector bench for muller_c_proj with hand-computed expectations.
module tb_muller_c_proj;

  logic       clk;
  logic       rst;
  logic [5:0] io_in;
  logic [2:0] c_pair;
  logic       c_all;
  logic       holding;
  logic [7:0] rise_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned exp_cnt  = 0;

  muller_c_proj #(
    .RESET_VAL(1'b0),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_in   (io_in),
    .c_pair  (c_pair),
    .c_all   (c_all),
    .holding (holding),
    .rise_cnt(rise_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, advance one rising edge, then settle.
  task automatic step(input logic [5:0] v, input logic r);
    @(negedge clk);
    io_in = v;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    io_in = 6'b111111;

    step(6'b111111, 1'b1);
    step(6'b111111, 1'b1);
    check("rst_pair", 32'(c_pair), 32'h0);
    check("rst_all", 32'(c_all), 32'h0);
    check("rst_cnt", 32'(rise_cnt), 32'h0);
    check("rst_hold", 32'(holding), 32'h0);

    step(6'b010010, 1'b0);
    check("mix_pair", 32'(c_pair), 32'h0);
    check("mix_all", 32'(c_all), 32'h0);
    check("mix_hold", 32'(holding), 32'h1);
    check("mix_cnt", 32'(rise_cnt), 32'h0);

    step(6'b111111, 1'b0);
    check("rise_pair", 32'(c_pair), 32'h7);
    check("rise_all", 32'(c_all), 32'h1);
    check("rise_cnt", 32'(rise_cnt), 32'h1);
    check("rise_hold", 32'(holding), 32'h0);

    step(6'b010010, 1'b0);
    check("hold1_pair", 32'(c_pair), 32'h5);
    check("hold1_all", 32'(c_all), 32'h1);
    check("hold1_hold", 32'(holding), 32'h1);
    check("hold1_cnt", 32'(rise_cnt), 32'h1);

    step(6'b000000, 1'b0);
    check("fall_pair", 32'(c_pair), 32'h0);
    check("fall_all", 32'(c_all), 32'h0);

    step(6'b000011, 1'b0);
    check("indep_pair", 32'(c_pair), 32'h1);
    check("indep_all", 32'(c_all), 32'h0);
    check("indep_hold", 32'(holding), 32'h1);
    check("indep_cnt", 32'(rise_cnt), 32'h1);

    step(6'b000000, 1'b1);
    check("rst2_cnt", 32'(rise_cnt), 32'h0);
    exp_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step(6'b000000, 1'b0);
      check("loop_fall", 32'(c_all), 32'h0);
      step(6'b111111, 1'b0);
      exp_cnt = (exp_cnt + 1) % 256;
      check("loop_rise", 32'(c_all), 32'h1);
      check("loop_cnt", 32'(rise_cnt), 32'(exp_cnt));
      if (i == 254) check("cnt_255", 32'(rise_cnt), 32'd255);
    end
    check("wrap_cnt", 32'(rise_cnt), 32'h0);

    step(6'b000000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(6'b000000, 1'b0);
      step(6'b111111, 1'b0);
    end
    check("pre_all", 32'(c_all), 32'h1);
    check("pre_cnt", 32'(rise_cnt), 32'd5);

    step(6'b111111, 1'b1);
    check("mid_rst_all", 32'(c_all), 32'h0);
    check("mid_rst_pair", 32'(c_pair), 32'h0);
    check("mid_rst_cnt", 32'(rise_cnt), 32'h0);

    step(6'b111111, 1'b0);
    check("post_all", 32'(c_all), 32'h1);
    check("post_pair", 32'(c_pair), 32'h7);
    check("post_cnt", 32'(rise_cnt), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
